// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage: datapath width, the
// bubble instruction, FSM state encoding, RISC-V field positions and the
// IF/ID register update selector.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 -- architectural no-op used as the IF/ID bubble
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // Fetch FSM states (kept as plain constants for compatibility with
   // existing tooling that inspects the state register directly)
   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   localparam logic [1:0] S_REDIR = 2'd3;

   // RISC-V base instruction field positions
   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;
   localparam int RS1_LSB    = 15;
   localparam int RS1_MSB    = 19;
   localparam int RS2_LSB    = 20;
   localparam int RS2_MSB    = 24;

   // What the IF/ID register does at the next edge
   typedef enum logic [1:0] {
      ID_HOLD,
      ID_BUBBLE,
      ID_FETCH,
      ID_SKID
   } id_sel_e;

   // Instruction fetches are always word aligned
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an instruction word that arrived from memory
// while the pipeline was stalled.
//   clk, rst        clock, asynchronous active-high reset
//   load            capture data_in/pc_in, mark full
//   pop             consume the held entry, mark empty
//   clear           discard the held entry (wins over load and pop)
//   data_in, pc_in  instruction word and its PC
//   full            entry present
//   data, pc        held instruction word and its PC
// -----------------------------------------------------------------------------
module fetch_skid_buf
   import fetch_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            pop,
   input  logic            clear,
   input  logic [XLEN-1:0] data_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            full,
   output logic [XLEN-1:0] data,
   output logic [XLEN-1:0] pc
);

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   // NOTE: the payload has no reset; it is only ever read while full=1, so
   // resetting it would add reset fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (load && !clear) begin
         data <= data_in;
         pc   <= pc_in;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage with IF/ID pipeline register. Issues word fetches
// to instruction memory, absorbs one in-flight word during a stall, and
// handles redirects (jumps) including one that lands while a memory access
// is still outstanding.
//   clk, rst                 clock, asynchronous active-high reset
//   stall_in                 hold IF/ID and PC
//   flush_in                 squash IF/ID and the skid entry
//   jump_in, jump_addr_in    redirect fetch (implies flush)
//   imem_req_out             fetch request
//   imem_addr_out            fetch address, stable while waiting for rdy
//   imem_rdy_in              access complete, imem_data_in valid
//   imem_data_in             fetched instruction word
//   instr_id_out, pc_id_out  IF/ID instruction and its PC
//   valid_id_out             IF/ID holds a real instruction
//   opcode/rd/rs1/rs2_id_out decoded register fields of instr_id_out
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [fetch_stage_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [fetch_stage_pkg::XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall_in,
   input  logic                             flush_in,
   input  logic                             jump_in,
   input  logic [fetch_stage_pkg::XLEN-1:0] jump_addr_in,
   output logic                             imem_req_out,
   output logic [fetch_stage_pkg::XLEN-1:0] imem_addr_out,
   input  logic                             imem_rdy_in,
   input  logic [fetch_stage_pkg::XLEN-1:0] imem_data_in,
   output logic [fetch_stage_pkg::XLEN-1:0] instr_id_out,
   output logic [fetch_stage_pkg::XLEN-1:0] pc_id_out,
   output logic                             valid_id_out,
   output logic [6:0]                       opcode_id_out,
   output logic [4:0]                       rd_id_out,
   output logic [4:0]                       rs1_id_out,
   output logic [4:0]                       rs2_id_out
);
   import fetch_stage_pkg::*;

   logic [1:0]      state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] hold_addr, hold_addr_n;  // address of the access being drained in S_REDIR
   id_sel_e         id_sel;
   logic            outstanding;
   logic            skid_load, skid_pop, skid_clear, skid_full;
   logic [XLEN-1:0] skid_data, skid_pc;

   assign imem_req_out  = (state == S_FETCH) || (state == S_REDIR);
   // While draining, the old address stays on the bus; pc already holds the target
   assign imem_addr_out = (state == S_REDIR) ? hold_addr : pc;
   assign outstanding   = imem_req_out && !imem_rdy_in;

   // NOTE: every signal assigned here gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      hold_addr_n = hold_addr;
      id_sel      = ID_HOLD;
      skid_load   = 1'b0;
      skid_pop    = 1'b0;
      skid_clear  = 1'b0;

      if (jump_in) begin
         pc_n       = word_align(jump_addr_in);
         id_sel     = ID_BUBBLE;
         skid_clear = 1'b1;
         if (outstanding) begin
            // A second jump while draining only replaces the target
            if (state == S_FETCH) hold_addr_n = pc;
            state_n = S_REDIR;
         end else begin
            state_n = S_FETCH;
         end
      end else if (flush_in) begin
         // PC is untouched, so a word arriving now is simply refetched later
         id_sel     = ID_BUBBLE;
         skid_clear = 1'b1;
         case (state)
            S_RESET, S_FULL: state_n = S_FETCH;
            S_REDIR:         if (imem_rdy_in) state_n = S_FETCH;
            default:         ;
         endcase
      end else begin
         case (state)
            S_RESET: begin
               state_n = S_FETCH;
               if (!stall_in) id_sel = ID_BUBBLE;
            end
            S_FETCH: begin
               if (imem_rdy_in) begin
                  pc_n = pc + 32'd4;
                  if (stall_in) begin
                     skid_load = 1'b1;
                     state_n   = S_FULL;
                  end else begin
                     id_sel = ID_FETCH;
                  end
               end else if (!stall_in) begin
                  id_sel = ID_BUBBLE;
               end
            end
            S_FULL: begin
               if (!stall_in) begin
                  skid_pop = 1'b1;
                  id_sel   = ID_SKID;
                  state_n  = S_FETCH;
               end
            end
            S_REDIR: begin
               // Returning data belongs to the abandoned path and is dropped
               if (imem_rdy_in) state_n = S_FETCH;
               if (!stall_in)   id_sel  = ID_BUBBLE;
            end
            default: state_n = S_RESET;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_RESET;
         pc           <= RESET_PC;
         hold_addr    <= '0;
         instr_id_out <= NOP_INSTR;
         pc_id_out    <= '0;
         valid_id_out <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         hold_addr <= hold_addr_n;
         case (id_sel)
            ID_BUBBLE: begin
               instr_id_out <= NOP_INSTR;
               valid_id_out <= 1'b0;
            end
            ID_FETCH: begin
               instr_id_out <= imem_data_in;
               pc_id_out    <= pc;
               valid_id_out <= 1'b1;
            end
            ID_SKID: begin
               instr_id_out <= skid_data;
               pc_id_out    <= skid_pc;
               valid_id_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .pop     (skid_pop),
      .clear   (skid_clear),
      .data_in (imem_data_in),
      .pc_in   (pc),
      .full    (skid_full),
      .data    (skid_data),
      .pc      (skid_pc)
   );

   assign opcode_id_out = instr_id_out[OPCODE_MSB:OPCODE_LSB];
   assign rd_id_out     = instr_id_out[RD_MSB:RD_LSB];
   assign rs1_id_out    = instr_id_out[RS1_MSB:RS1_LSB];
   assign rs2_id_out    = instr_id_out[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. Memory returns mem[a] = a. A
// behavioural model predicts the fetch address and the sequence of real
// instructions that reach IF/ID; predicted instructions go into a scoreboard
// queue that an independent monitor drains whenever IF/ID presents a new
// valid instruction.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        flush_in = 1'b0;
   logic        jump_in = 1'b0;
   logic [31:0] jump_addr_in = '0;
   logic        imem_rdy_in = 1'b0;
   logic [31:0] imem_data_in;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic [31:0] instr_id_out;
   logic [31:0] pc_id_out;
   logic        valid_id_out;
   logic [6:0]  opcode_id_out;
   logic [4:0]  rd_id_out, rs1_id_out, rs2_id_out;

   always #5 clk = ~clk;

   // Instruction memory: every word holds its own address
   assign imem_data_in = imem_addr_out;

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_in      (stall_in),
      .flush_in      (flush_in),
      .jump_in       (jump_in),
      .jump_addr_in  (jump_addr_in),
      .imem_req_out  (imem_req_out),
      .imem_addr_out (imem_addr_out),
      .imem_rdy_in   (imem_rdy_in),
      .imem_data_in  (imem_data_in),
      .instr_id_out  (instr_id_out),
      .pc_id_out     (pc_id_out),
      .valid_id_out  (valid_id_out),
      .opcode_id_out (opcode_id_out),
      .rd_id_out     (rd_id_out),
      .rs1_id_out    (rs1_id_out),
      .rs2_id_out    (rs2_id_out)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   int     checks   = 0;
   int     failures = 0;
   entry_t sb_q[$];

   // Reference model: next fetch address, words parked during a stall,
   // and a pending redirect that still has to drain an old access.
   bit          m_first;
   bit          m_redir;
   logic [31:0] m_pc;
   logic [31:0] m_old;
   entry_t      m_park[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_first = 1'b1;
      m_redir = 1'b0;
      m_pc    = 32'h0000_0000;
      m_old   = 32'h0000_0000;
      m_park.delete();
   endfunction

   // One clock cycle: check this cycle's fetch request against the model,
   // apply the inputs, then advance the model by the same rules.
   task automatic step(input logic s, input logic f, input logic j,
                       input logic [31:0] ja, input logic r);
      logic        exp_req;
      logic [31:0] exp_addr;
      entry_t      e;
      @(negedge clk);
      exp_req  = !m_first && (m_park.size() == 0);
      exp_addr = m_redir ? m_old : m_pc;
      check("imem_req", 32'(imem_req_out), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr_out, exp_addr);
      stall_in     = s;
      flush_in     = f;
      jump_in      = j;
      jump_addr_in = ja;
      imem_rdy_in  = r;
      if (j) begin
         m_park.delete();
         if (exp_req && !r) begin
            if (!m_redir) m_old = exp_addr;
            m_redir = 1'b1;
         end else begin
            m_redir = 1'b0;
         end
         m_pc    = ja & ~32'h3;
         m_first = 1'b0;
      end else if (f) begin
         m_park.delete();
         if (m_redir && r) m_redir = 1'b0;
         m_first = 1'b0;
      end else if (m_first) begin
         m_first = 1'b0;
      end else if (m_redir) begin
         if (r) m_redir = 1'b0;
      end else if (m_park.size() != 0) begin
         if (!s) sb_q.push_back(m_park.pop_front());
      end else if (r) begin
         e.instr = m_pc;
         e.pc    = m_pc;
         m_pc    = m_pc + 32'd4;
         if (s) m_park.push_back(e);
         else   sb_q.push_back(e);
      end
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic do_reset(input logic late_rdy);
      @(negedge clk);
      #2;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      stall_in    = 1'b0;
      flush_in    = 1'b0;
      jump_in     = 1'b0;
      rst         = 1'b1;
      #1;
      check("rst_req",   32'(imem_req_out), 32'd0);
      check("rst_instr", instr_id_out, NOP);
      check("rst_pc_id", pc_id_out, 32'd0);
      check("rst_valid", 32'(valid_id_out), 32'd0);
      imem_rdy_in = late_rdy;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: pop and compare whenever a new instruction enters IF/ID
   logic        mon_prev_valid = 1'b0;
   logic [31:0] mon_prev_pc = '0;

   initial begin : monitor
      entry_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_prev_valid = 1'b0;
         end else begin
            if (valid_id_out && (!mon_prev_valid || pc_id_out != mon_prev_pc)) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL id_unexpected: got pc 0x%08h instr 0x%08h, expected no instruction at t=%0t",
                           pc_id_out, instr_id_out, $time);
               end else begin
                  e = sb_q.pop_front();
                  check("id_instr", instr_id_out, e.instr);
                  check("id_pc", pc_id_out, e.pc);
                  check("id_fields", {10'b0, opcode_id_out, rd_id_out, rs1_id_out, rs2_id_out},
                        {10'b0, e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20]});
               end
            end else if (!valid_id_out) begin
               check("bubble_instr", instr_id_out, NOP);
            end
            mon_prev_valid = valid_id_out;
            mon_prev_pc    = pc_id_out;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic        s, f, j, r;
      logic [31:0] ja;
      model_reset();

      // Straight-line fetch, then a three-cycle memory wait at 0x8
      do_reset(1'b0);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);  check("seq_addr0", imem_addr_out, 32'h0);
      step(0, 0, 0, 32'h0, 1);  check("seq_addr4", imem_addr_out, 32'h4);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 32'h0, 0);
         check("wait_addr", imem_addr_out, 32'h8);
      end
      step(0, 0, 0, 32'h0, 1);  check("wait_bubble", 32'(valid_id_out), 32'd0);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);

      // Two-cycle stall with a word parked in the skid buffer
      do_reset(1'b0);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);
      step(1, 0, 0, 32'h0, 1);  check("stall_hold_instr", instr_id_out, 32'h4);
      step(1, 0, 0, 32'h0, 1);  check("stall_req_low", 32'(imem_req_out), 32'd0);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);  check("stall_release", instr_id_out, 32'h8);
      step(0, 0, 0, 32'h0, 1);  check("stall_next", instr_id_out, 32'hC);

      // Jump while an access at 0x10 is outstanding
      do_reset(1'b0);
      step(0, 0, 0, 32'h0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 0);   check("redir_wait_addr", imem_addr_out, 32'h10);
      step(0, 0, 1, 32'h103, 0);
      step(0, 0, 0, 32'h0, 0);   check("redir_hold_addr", imem_addr_out, 32'h10);
      check("redir_valid", 32'(valid_id_out), 32'd0);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);   check("redir_target", imem_addr_out, 32'h100);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);

      // Jump+stall with full skid, then a reset pulse mid-wait with late rdy
      do_reset(1'b0);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);
      step(1, 0, 0, 32'h0, 1);
      step(1, 0, 1, 32'h100, 1);
      step(0, 0, 0, 32'h0, 0);   check("js_addr", imem_addr_out, 32'h100);
      step(0, 0, 0, 32'h0, 0);
      do_reset(1'b1);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);   check("post_rst_addr", imem_addr_out, 32'h0);

      // Randomised traffic, including jumps near the top of the address space
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 19) == 0);
         j = ($urandom_range(0, 24) == 0);
         r = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 7) == 0) ja = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else                           ja = 32'($urandom_range(0, 4095));
         step(s, f, j, ja, r);
      end

      // Drain anything parked, then confirm nothing predicted went missing
      for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 0);
      @(negedge clk);
      #2;
      check("final_drain", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
